data_cache: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache.
- Serves as the responder on the CPU stage-4 data memory interface: consumes memReadEn/memWriteEn/address/store data and returns load data and DATA_CACHE_BUSY_WAIT.
- On a miss, initiates block transfers to a slower backing data memory over a 128-bit block interface.

---
 rtl/data_cache_pkg.sv | 27 ++
 rtl/data_cache_lane.sv | 47 ++++
 rtl/data_cache.sv | 168 ++++++++++++++++
 tb/tb_data_cache.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_cache_pkg.sv
// data_cache_pkg: shared constants for the data cache slice.
//   - FSM state encoding (IDLE, WRITEBACK, FETCH, UPDATE)
//   - load funct3 and store size codes seen on READ_EN[2:0] / WRITE_EN[1:0]
//   - block geometry (16-byte blocks, 128-bit block bus)
package data_cache_pkg;

    localparam int unsigned BLOCK_W  = 128;
    localparam int unsigned OFFSET_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE      = 2'd0;
    localparam state_t WRITEBACK = 2'd1;
    localparam state_t FETCH     = 2'd2;
    localparam state_t UPDATE    = 2'd3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

endpackage

// File: rtl/data_cache_lane.sv
// data_cache_lane: purely combinational word-lane helper.
//   word        in  32  selected cache word
//   byte_sel    in  2   ADDRESS[1:0]
//   funct3      in  3   load type (LB/LH/LW/LBU/LHU, others return full word)
//   size        in  2   store size (SB/SH/SW)
//   store_data  in  32  right-aligned store data
//   load_data   out 32  extracted and extended load value
//   merged_word out 32  word with store data merged into its lane
module data_cache_lane
    import data_cache_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_sel,
    input  logic [2:0]  funct3,
    input  logic [1:0]  size,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Halfword lane is chosen by byte_sel[1] only; byte_sel[0] is ignored.
    assign load_byte = word[{byte_sel, 3'b000} +: 8];
    assign load_half = word[{byte_sel[1], 4'b0000} +: 16];

    always_comb begin
        case (funct3)
            F3_LB:   load_data = {{24{load_byte[7]}}, load_byte};
            F3_LH:   load_data = {{16{load_half[15]}}, load_half};
            F3_LBU:  load_data = {24'd0, load_byte};
            F3_LHU:  load_data = {16'd0, load_half};
            default: load_data = word;
        endcase
    end

    always_comb begin
        merged_word = word;
        case (size)
            SZ_B:    merged_word[{byte_sel, 3'b000} +: 8] = store_data[7:0];
            SZ_H:    merged_word[{byte_sel[1], 4'b0000} +: 16] = store_data[15:0];
            default: merged_word = store_data;
        endcase
    end

endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache with 16-byte
// blocks, sitting between the CPU memory stage and a slower block memory.
//   CLK, RESET            clock, synchronous active-high reset
//   READ_EN[3:0]          [3] load request, [2:0] funct3
//   WRITE_EN[2:0]         [2] store request, [1:0] size
//   ADDRESS, WRITE_DATA   byte address, right-aligned store data
//   READ_DATA             load result (0 when no load request)
//   BUSY_WAIT             CPU stall
//   MEM_READ/MEM_WRITE    block memory strobes (state-decoded)
//   MEM_ADDRESS[27:0]     block address, MEM_WRITE_DATA evicted block
//   MEM_READ_DATA         fetched block, MEM_BUSY_WAIT memory busy
// Optional: define DATA_CACHE_STATS_EN to add HIT_COUNT / MISS_COUNT outputs.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int unsigned CACHE_LINES = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [3:0]           READ_EN,
    input  logic [2:0]           WRITE_EN,
    input  logic [31:0]          ADDRESS,
    input  logic [31:0]          WRITE_DATA,
    output logic [31:0]          READ_DATA,
    output logic                 BUSY_WAIT,
    output logic                 MEM_READ,
    output logic                 MEM_WRITE,
    output logic [27:0]          MEM_ADDRESS,
    output logic [BLOCK_W-1:0]   MEM_WRITE_DATA,
    input  logic [BLOCK_W-1:0]   MEM_READ_DATA,
    input  logic                 MEM_BUSY_WAIT
`ifdef DATA_CACHE_STATS_EN
    ,
    output logic [31:0]          HIT_COUNT,
    output logic [31:0]          MISS_COUNT
`endif
);

    localparam int unsigned INDEX_W = $clog2(CACHE_LINES);
    localparam int unsigned TAG_W   = 28 - INDEX_W;

    // Address fields
    logic [TAG_W-1:0]   addr_tag;
    logic [INDEX_W-1:0] addr_index;
    logic [1:0]         addr_word;

    assign addr_tag   = ADDRESS[31:OFFSET_W+INDEX_W];
    assign addr_index = ADDRESS[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign addr_word  = ADDRESS[3:2];

    // Line storage; only valid/dirty are reset, tag/data are don't-care until valid.
    logic [CACHE_LINES-1:0] valid_q;
    logic [CACHE_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]       tag_q   [CACHE_LINES];
    logic [BLOCK_W-1:0]     block_q [CACHE_LINES];

    state_t state_q, state_d;

    logic               store_req, load_req, request, hit;
    logic               idle_miss, store_hit;
    logic [BLOCK_W-1:0] cur_block, store_block;
    logic [31:0]        cur_word, load_word, merged_word;

    // A simultaneous load and store is treated as a store only.
    assign store_req = WRITE_EN[2];
    assign load_req  = READ_EN[3] & ~store_req;
    assign request   = READ_EN[3] | WRITE_EN[2];

    assign cur_block = block_q[addr_index];
    assign cur_word  = cur_block[{addr_word, 5'b00000} +: 32];
    assign hit       = valid_q[addr_index] && (tag_q[addr_index] == addr_tag);

    assign idle_miss = (state_q == IDLE) && request && !hit;
    assign store_hit = (state_q == IDLE) && store_req && hit;

    data_cache_lane u_lane (
        .word        (cur_word),
        .byte_sel    (ADDRESS[1:0]),
        .funct3      (READ_EN[2:0]),
        .size        (WRITE_EN[1:0]),
        .store_data  (WRITE_DATA),
        .load_data   (load_word),
        .merged_word (merged_word)
    );

    always_comb begin
        store_block = cur_block;
        store_block[{addr_word, 5'b00000} +: 32] = merged_word;
    end

    // Load data is only meaningful while BUSY_WAIT is low.
    assign READ_DATA = load_req ? load_word : 32'd0;

    // FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (idle_miss) begin
                    state_d = dirty_q[addr_index] ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                if (!MEM_BUSY_WAIT) state_d = FETCH;
            end
            FETCH: begin
                if (!MEM_BUSY_WAIT) state_d = UPDATE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    assign BUSY_WAIT = idle_miss || (state_q != IDLE);
    assign MEM_WRITE = (state_q == WRITEBACK);
    assign MEM_READ  = (state_q == FETCH);

    // Write-back targets the resident block; fetch targets the requested one.
    assign MEM_ADDRESS    = (state_q == WRITEBACK) ? {tag_q[addr_index], addr_index}
                                                   : {addr_tag, addr_index};
    assign MEM_WRITE_DATA = cur_block;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (state_q == UPDATE) begin
            valid_q[addr_index] <= 1'b1;
            dirty_q[addr_index] <= 1'b0;
        end else if (store_hit) begin
            dirty_q[addr_index] <= 1'b1;
        end
    end

    // Reset aborts any fill or store so no line changes on the reset edge.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (state_q == UPDATE) begin
                tag_q[addr_index]   <= addr_tag;
                block_q[addr_index] <= MEM_READ_DATA;
            end else if (store_hit) begin
                block_q[addr_index] <= store_block;
            end
        end
    end

`ifdef DATA_CACHE_STATS_EN
    logic [31:0] hit_count_q, miss_count_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
        end else begin
            if ((state_q == IDLE) && request && hit) hit_count_q <= hit_count_q + 32'd1;
            if (idle_miss)                           miss_count_q <= miss_count_q + 32'd1;
        end
    end

    assign HIT_COUNT  = hit_count_q;
    assign MISS_COUNT = miss_count_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: self-checking bench for data_cache. A flat architectural memory
// model plus a record of which block each line holds predicts every output; a
// latency-programmable block memory answers the cache's transfers.
module tb_data_cache;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic [3:0]   READ_EN = '0;
    logic [2:0]   WRITE_EN = '0;
    logic [31:0]  ADDRESS = '0;
    logic [31:0]  WRITE_DATA = '0;
    logic [31:0]  READ_DATA;
    logic         BUSY_WAIT, MEM_READ, MEM_WRITE, MEM_BUSY_WAIT;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_WRITE_DATA;
    logic [127:0] MEM_READ_DATA = '0;
`ifdef DATA_CACHE_STATS_EN
    logic [31:0]  HIT_COUNT, MISS_COUNT;
    logic         lit_st_en = 1'b0;
`endif

    always #5 CLK = ~CLK;

    data_cache dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .READ_EN        (READ_EN),
        .WRITE_EN       (WRITE_EN),
        .ADDRESS        (ADDRESS),
        .WRITE_DATA     (WRITE_DATA),
        .READ_DATA      (READ_DATA),
        .BUSY_WAIT      (BUSY_WAIT),
        .MEM_READ       (MEM_READ),
        .MEM_WRITE      (MEM_WRITE),
        .MEM_ADDRESS    (MEM_ADDRESS),
        .MEM_WRITE_DATA (MEM_WRITE_DATA),
        .MEM_READ_DATA  (MEM_READ_DATA),
        .MEM_BUSY_WAIT  (MEM_BUSY_WAIT)
`ifdef DATA_CACHE_STATS_EN
        ,
        .HIT_COUNT      (HIT_COUNT),
        .MISS_COUNT     (MISS_COUNT)
`endif
    );

    // ---------------- block memory (addresses kept below 1 KiB) ----------------
    logic [127:0] bmem [64];
    logic         bset [64];
    int unsigned  mem_lat = 0;
    int unsigned  mcnt = 0;

    function automatic logic [127:0] init_blk(input logic [27:0] ba);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) begin
            r[k*32 +: 32] = (32'(ba) * 32'h9E37_79B1) ^ (32'(k) * 32'h7F4A_7C15) ^ 32'h1357_9BDF;
        end
        if (ba == 28'h4) r[31:0] = 32'hDEAD_BEEF;
        return r;
    endfunction

    function automatic logic [127:0] backing(input logic [27:0] ba);
        return bset[ba[5:0]] ? bmem[ba[5:0]] : init_blk(ba);
    endfunction

    assign MEM_BUSY_WAIT = (MEM_READ || MEM_WRITE) && (mcnt != mem_lat);

    always @(posedge CLK) begin
        if (MEM_READ || MEM_WRITE) begin
            if (mcnt == mem_lat) begin
                if (MEM_WRITE) begin
                    bmem[MEM_ADDRESS[5:0]] <= MEM_WRITE_DATA;
                    bset[MEM_ADDRESS[5:0]] <= 1'b1;
                end else begin
                    MEM_READ_DATA <= backing(MEM_ADDRESS);
                end
                mcnt <= 0;
            end else begin
                mcnt <= mcnt + 1;
            end
        end else begin
            mcnt <= 0;
        end
    end

    // ---------------- reference model ----------------
    logic [127:0] rmem [64];
    logic         rset [64];
    logic         mvalid [8];
    logic         mdirty [8];
    logic [27:0]  mblk [8];
    logic [31:0]  mhits, mmiss;
    int           phase;
    bit           in_miss = 1'b0;
    logic [27:0]  wb_blk, fill_blk;
    logic [2:0]   fill_idx;
    int           total = 0;
    int           bad = 0;
    bit           timed_out = 1'b0;

    bit           lit_rd_en = 1'b0, lit_fe_en = 1'b0, lit_wb_en = 1'b0;
    logic [31:0]  lit_rd;
    logic [27:0]  lit_fe, lit_wb;
    logic [31:0]  lit_wb_w1;

    function automatic logic [127:0] get_ref(input logic [27:0] ba);
        return rset[ba[5:0]] ? rmem[ba[5:0]] : backing(ba);
    endfunction

    function automatic logic [31:0] ld_val(input logic [127:0] blk, input logic [31:0] a,
                                           input logic [2:0] f);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        w = blk[32 * int'(a[3:2]) +: 32];
        b = w[8 * int'(a[1:0]) +: 8];
        h = w[16 * int'(a[1]) +: 16];
        case (f)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [127:0] st_val(input logic [127:0] blk, input logic [31:0] a,
                                            input logic [1:0] sz, input logic [31:0] d);
        logic [127:0] r;
        int base;
        int n;
        r = blk;
        base = 4 * int'(a[3:2]);
        case (sz)
            2'b00:   begin base += int'(a[1:0]);   n = 1; end
            2'b01:   begin base += 2 * int'(a[1]); n = 2; end
            default: n = 4;
        endcase
        for (int j = 0; j < n; j++) r[(base + j) * 8 +: 8] = d[j*8 +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every negedge, outputs are checked against the model.
    initial begin : compare
        logic [27:0]  ba;
        logic [2:0]   idx;
        logic         st, ld, req, miss;
        logic [127:0] blk;
        forever begin
            @(negedge CLK);
            check("no_timeout", timed_out, 0);
            if (RESET) begin
                for (int i = 0; i < 8; i++) begin
                    mvalid[i] = 1'b0;
                    mdirty[i] = 1'b0;
                end
                for (int i = 0; i < 64; i++) rset[i] = 1'b0;
                in_miss = 1'b0;
                mhits = 0;
                mmiss = 0;
            end else begin
                ba  = ADDRESS[31:4];
                idx = ADDRESS[6:4];
                st  = WRITE_EN[2];
                ld  = READ_EN[3] && !st;
                req = st || READ_EN[3];
                check("strobe_exclusive", MEM_READ && MEM_WRITE, 0);
                if (!in_miss) begin
                    miss = req && !(mvalid[idx] && (mblk[idx] == ba));
                    check("busy_idle", BUSY_WAIT, miss);
                    check("mem_read_idle", MEM_READ, 0);
                    check("mem_write_idle", MEM_WRITE, 0);
`ifdef DATA_CACHE_STATS_EN
                    check("hit_count", HIT_COUNT, mhits);
                    check("miss_count", MISS_COUNT, mmiss);
                    if (lit_st_en) begin
                        check("hit_count_lit", HIT_COUNT, 32'd4);
                        check("miss_count_lit", MISS_COUNT, 32'd1);
                    end
`endif
                    if (!ld) check("read_data_zero", READ_DATA, 0);
                    if (req && !miss) begin
                        mhits++;
                        if (st) begin
                            blk = st_val(get_ref(ba), ADDRESS, WRITE_EN[1:0], WRITE_DATA);
                            rmem[ba[5:0]] = blk;
                            rset[ba[5:0]] = 1'b1;
                            mdirty[idx] = 1'b1;
                        end else begin
                            check("load", READ_DATA, ld_val(get_ref(ba), ADDRESS, READ_EN[2:0]));
                            if (lit_rd_en) check("load_lit", READ_DATA, lit_rd);
                        end
                    end else if (miss) begin
                        mmiss++;
                        in_miss  = 1'b1;
                        wb_blk   = mblk[idx];
                        fill_blk = ba;
                        fill_idx = idx;
                        phase    = (mvalid[idx] && mdirty[idx]) ? 1 : 2;
                    end
                end else begin
                    check("busy_miss", BUSY_WAIT, 1);
                    case (phase)
                        1: begin
                            check("wb_strobe", {MEM_WRITE, MEM_READ}, 2'b10);
                            check("wb_addr", MEM_ADDRESS, wb_blk);
                            check("wb_data", MEM_WRITE_DATA, get_ref(wb_blk));
                            if (lit_wb_en) begin
                                check("wb_addr_lit", MEM_ADDRESS, lit_wb);
                                check("wb_word1_lit", MEM_WRITE_DATA[63:32], lit_wb_w1);
                            end
                            if (!MEM_BUSY_WAIT) phase = 2;
                        end
                        2: begin
                            check("fetch_strobe", {MEM_WRITE, MEM_READ}, 2'b01);
                            check("fetch_addr", MEM_ADDRESS, fill_blk);
                            if (lit_fe_en) check("fetch_addr_lit", MEM_ADDRESS, lit_fe);
                            if (!MEM_BUSY_WAIT) phase = 3;
                        end
                        default: begin
                            check("update_strobe", {MEM_WRITE, MEM_READ}, 2'b00);
                            mvalid[fill_idx] = 1'b1;
                            mdirty[fill_idx] = 1'b0;
                            mblk[fill_idx]   = fill_blk;
                            in_miss = 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wrap_up();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic idle(input int n);
        READ_EN  = '0;
        WRITE_EN = '0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic access(input bit st, input bit also_ld, input logic [2:0] f,
                          input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int n;
        READ_EN    = st ? {also_ld, f} : {1'b1, f};
        WRITE_EN   = st ? {1'b1, sz} : 3'b000;
        ADDRESS    = a;
        WRITE_DATA = d;
        n = 0;
        @(negedge CLK);
        while (BUSY_WAIT && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (BUSY_WAIT) begin
            timed_out = 1'b1;
            @(negedge CLK);
            wrap_up();
        end
        @(posedge CLK);
        #1;
        READ_EN  = '0;
        WRITE_EN = '0;
    endtask

    task automatic load_lit(input logic [2:0] f, input logic [31:0] a, input logic [31:0] exp);
        lit_rd_en = 1'b1;
        lit_rd    = exp;
        access(0, 0, f, 2'b00, a, 32'd0);
        lit_rd_en = 1'b0;
    endtask

    initial begin : stimulus
        int n;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        idle(2);

        // Cold read of line 4
        mem_lat = 5;
        lit_fe_en = 1'b1;
        lit_fe    = 28'h4;
        load_lit(3'b010, 32'h40, 32'hDEAD_BEEF);
        lit_fe_en = 1'b0;

        // Store hit, then load back
        access(1, 0, 3'b000, 2'b10, 32'h44, 32'h1234_5678);
        load_lit(3'b010, 32'h44, 32'h1234_5678);

        // Sub-word access
        access(1, 0, 3'b000, 2'b10, 32'h48, 32'h80FF_7F01);
        load_lit(3'b000, 32'h48, 32'h0000_0001);
        load_lit(3'b000, 32'h4B, 32'hFFFF_FF80);
        load_lit(3'b100, 32'h4B, 32'h0000_0080);
        load_lit(3'b001, 32'h4A, 32'hFFFF_80FF);
        access(1, 0, 3'b000, 2'b00, 32'h49, 32'h0000_00AA);
        load_lit(3'b010, 32'h48, 32'h80FF_AA01);
        idle(1);

        // Dirty eviction of line 4
        mem_lat   = 2;
        lit_wb_en = 1'b1;
        lit_wb    = 28'h4;
        lit_wb_w1 = 32'h1234_5678;
        lit_fe_en = 1'b1;
        lit_fe    = 28'hC;
        access(0, 0, 3'b010, 2'b00, 32'hC0, 32'd0);
        lit_wb_en = 1'b0;
        lit_fe_en = 1'b0;

        // Reset during FETCH
        mem_lat = 8;
        READ_EN = 4'b1010;
        ADDRESS = 32'h100;
        n = 0;
        @(negedge CLK);
        while (!MEM_READ && n < 20) begin
            @(negedge CLK);
            n++;
        end
        @(posedge CLK);
        #1;
        RESET   = 1'b1;
        READ_EN = '0;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        idle(1);

        // Reissued load misses again, then three hits
        mem_lat   = 3;
        lit_fe_en = 1'b1;
        lit_fe    = 28'h10;
        access(0, 0, 3'b010, 2'b00, 32'h100, 32'd0);
        lit_fe_en = 1'b0;
        access(0, 0, 3'b010, 2'b00, 32'h100, 32'd0);
        access(0, 0, 3'b001, 2'b00, 32'h102, 32'd0);
        access(1, 0, 3'b000, 2'b10, 32'h104, 32'hCAFE_F00D);
`ifdef DATA_CACHE_STATS_EN
        lit_st_en = 1'b1;
`endif
        idle(1);
`ifdef DATA_CACHE_STATS_EN
        lit_st_en = 1'b0;
`endif

        // Randomized traffic over 64 blocks (8 lines x 8 tags)
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            mem_lat = $urandom_range(0, 4);
            a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 1) begin
                access(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                       2'($urandom_range(0, 2)), a, $urandom);
            end else begin
                access(0, 0, 3'($urandom_range(0, 7)), 2'b00, a, 32'd0);
            end
            if ($urandom_range(0, 7) == 0) idle(1);
        end

        idle(2);
        wrap_up();
    end

endmodule
